// File: rtl/mdr_store_buffer.sv
// Store buffer between the datapath and data memory: FIFO of {addr, data} drained over mem_we/mem_ack.
// Optional `define STORE_FWD_EN forwards youngest matching store data instead of flagging a read hazard.
module mdr_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dmem_write,
    input  logic [AW-1:0] AR_in,
    input  logic [DW-1:0] MDR_out,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic          mem_ack,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_hazard,
    output logic          rd_hit,
    output logic [DW-1:0] rd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            overflow_q, overflow_d;
    logic [AW-1:0]   addr_q [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];

    logic            full_w;
    logic            push;
    logic            pop;
    logic [PW-1:0]   head_nxt;

    assign full_w   = (count_q == CW'(DEPTH));
    assign push     = dmem_write && !full_w;
    assign pop      = (state_q == S_WRITE) && mem_ack;
    assign head_nxt = rd_ptr_q + PW'(1);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        overflow_d  = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (dmem_write && full_w) begin
            overflow_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                mem_we_d = 1'b0;
                if (count_q != '0) begin
                    mem_addr_d  = addr_q[rd_ptr_q];
                    mem_wdata_d = data_q[rd_ptr_q];
                    mem_we_d    = 1'b1;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    rd_ptr_d = head_nxt;
                    if (count_q > CW'(1)) begin
                        mem_addr_d  = addr_q[head_nxt];
                        mem_wdata_d = data_q[head_nxt];
                    end else if (push) begin
                        // Lone head popped while a store lands in the slot that becomes the new head.
                        mem_addr_d  = AR_in;
                        mem_wdata_d = MDR_out;
                    end else begin
                        mem_we_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (push) begin
            addr_q[wr_ptr_q] <= AR_in;
            data_q[wr_ptr_q] <= MDR_out;
        end
    end

    // Lookup walks oldest to youngest so the last match seen is the youngest.
    logic          match_any;
    logic [PW-1:0] lk_idx;

`ifdef STORE_FWD_EN
    logic [DW-1:0] fwd_data;

    always_comb begin
        match_any = 1'b0;
        fwd_data  = '0;
        lk_idx    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            lk_idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[lk_idx] == rd_addr)) begin
                match_any = 1'b1;
                fwd_data  = data_q[lk_idx];
            end
        end
    end

    assign rd_hit    = match_any;
    assign rd_data   = fwd_data;
    assign rd_hazard = 1'b0;
`else
    always_comb begin
        match_any = 1'b0;
        lk_idx    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            lk_idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[lk_idx] == rd_addr)) begin
                match_any = 1'b1;
            end
        end
    end

    assign rd_hazard = match_any;
    assign rd_hit    = 1'b0;
    assign rd_data   = '0;
`endif

    assign full      = full_w;
    assign empty     = (count_q == '0) && !mem_we_q;
    assign overflow  = overflow_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mdr_store_buffer.md
# mdr_store_buffer

Write-side companion to the MDR load path. Accepts store requests (address from AR, data from MDR) issued by the control unit. Buffers them in a small FIFO and drains them to data memory over a write-enable/acknowledge handshake, so the datapath does not stall on memory write latency. Also flags or forwards reads that hit a buffered, not-yet-committed store.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores; power of two, ≥2
- AW, 16, address width
- DW, 16, data width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- dmem_write  in  1  store request strobe from control unit; one store per high cycle
- AR_in  in  AW  store address
- MDR_out  in  DW  store data
- full  out  1  buffer holds DEPTH entries
- empty  out  1  buffer holds no entries and no write is in flight
- overflow  out  1  sticky: a store was issued while full
- mem_addr  out  AW  data-memory write address
- mem_wdata  out  DW  data-memory write data
- mem_we  out  1  data-memory write request
- mem_ack  in  1  data memory accepted the current write
- rd_addr  in  AW  address of the pending data-memory read
- rd_hazard  out  1  rd_addr matches a buffered store (non-forwarding build)
- rd_hit  out  1  forwarded data valid (forwarding build)
- rd_data  out  DW  forwarded store data (forwarding build)

## Operation
- Storage: DEPTH-entry FIFO of {addr, data}. wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Enqueue: when dmem_write=1 and full=0, write {AR_in, MDR_out} at wr_ptr, then increment wr_ptr.
- Store while full: dmem_write=1 with full=1 drops the request and sets overflow. A pop in the same cycle does not rescue it. overflow clears only on reset.
- The head entry stays in the FIFO until acknowledged. The in-flight write is always the head entry.
- Drain FSM, two states:
  - IDLE: mem_we=0. If count>0, load mem_addr/mem_wdata from the head, set mem_we=1, go to WRITE.
  - WRITE: hold mem_we, mem_addr and mem_wdata stable until mem_ack=1. On the mem_ack edge, pop (rd_ptr+1).
    - If entries remain after the pop, load the next head and stay in WRITE with mem_we=1 (back-to-back writes).
    - Otherwise clear mem_we and go to IDLE.
- mem_ack is ignored while mem_we=0.
- Simultaneous enqueue and pop: count unchanged; both pointers advance.
- full = (count==DEPTH). empty = (count==0).
- Lookup compares rd_addr against all count valid entries, in-flight head included. Match logic is combinational from registered state only. A store enqueued in the same cycle is not visible to the lookup until the next cycle.

## Timing
- Reset (async assert, sync release) sets:
  - wr_ptr=rd_ptr=count=0, FSM=IDLE
  - mem_we=0, mem_addr=0, mem_wdata=0
  - full=0, empty=1, overflow=0
  - rd_hazard=0, rd_hit=0, rd_data=0
- Reset mid-write drops mem_we immediately and discards all buffered stores.
- Latency into an empty buffer: enqueue at edge N gives mem_we=1 with valid addr/data after edge N+1.
- Back-to-back throughput: one store per cycle when mem_ack is held high.
- Write completion: pop takes effect at the edge where mem_ack=1. count, full and empty update at that same edge.
- full, empty, overflow and mem_* are registered or decoded from registers only; there is no combinational path from dmem_write, AR_in or mem_ack.

## Configuration
- Macro STORE_FWD_EN.
- Defined:
  - On a match, rd_hit=1 and rd_data = data of the youngest matching entry (closest to wr_ptr).
  - rd_hazard is tied 0.
- Undefined:
  - rd_hazard=1 on any match; the control unit must stall the read.
  - rd_hit and rd_data are tied 0.
  - No forwarding mux is built.

## Test plan
- Reset, then a single store of addr 0x0010 / data 0xBEEF with mem_ack high one cycle after mem_we → mem_we high exactly one cycle after enqueue with addr 0x0010 / data 0xBEEF, then empty=1.
- mem_ack held low for 5 cycles with 4 stores enqueued → full=1; a 5th store sets overflow=1 and is never written. After acks, exactly 4 writes occur in enqueue order.
- mem_ack held high with a continuous store every cycle → one write per cycle. Pointers wrap past DEPTH and data order is preserved.
- Stores to 0x0020 with data 0x1111 then 0x2222, then rd_addr=0x0020 → with STORE_FWD_EN: rd_hit=1, rd_data=0x2222. Without it: rd_hazard=1. After both acks: no hit or hazard.
- Simultaneous enqueue and ack at count=2 → count stays 2, and the next mem_wdata is the second-oldest entry.
- reset asserted while mem_we=1 with 3 entries → mem_we=0 immediately, empty=1, and no further writes after release.
